// File: rtl/stream_demux2.sv
// stream_demux2: registered 1-to-2 packet stream demultiplexer.
// A whole packet is steered to output 0 or 1 by s_sel sampled on its first
// beat. Each output owns a one-entry register, so the two outputs drain
// independently and a sustained one-beat-per-cycle flow is possible.
module stream_demux2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_sel,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_last,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_last,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;

  state_t              r_state;
  logic                w_tgt;
  logic                w_accept;
  logic [1:0]          w_m_ready;
  logic [1:0]          w_load;
  logic [1:0]          r_valid;
  logic [1:0]          r_last;
  logic [DATA_W-1:0]   r_data [2];
  logic [CNT_W-1:0]    r_cnt  [2];

  assign w_m_ready = {m1_ready, m0_ready};

  // Target output: s_sel only matters between packets, otherwise the lock holds.
  always_comb begin
    case (r_state)
      ROUTE0:  w_tgt = 1'b0;
      ROUTE1:  w_tgt = 1'b1;
      default: w_tgt = s_sel;
    endcase
  end

  // Ready depends only on the target register, never on s_valid.
  assign s_ready  = rst_n & (~r_valid[w_tgt] | w_m_ready[w_tgt]);
  assign w_accept = s_valid & s_ready;

  // One-hot load strobe for the output register receiving this beat.
  always_comb begin
    w_load         = 2'b00;
    w_load[w_tgt]  = w_accept;
  end

  // Packet-lock FSM: advances only on handshaken beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (w_accept) begin
      if (s_last) begin
        r_state <= IDLE;
      end else if (r_state == IDLE) begin
        r_state <= w_tgt ? ROUTE1 : ROUTE0;
      end
    end
  end

  // Per-output pipeline registers: load wins over drain so a full register
  // can be refilled in the same cycle it empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 2'b00;
      r_last  <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= s_data;
          r_last[k]  <= s_last;
        end else if (r_valid[k] && w_m_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Completed-packet counters: count last beats accepted downstream, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_valid[k] && w_m_ready[k] && r_last[k]) begin
          r_cnt[k] <= r_cnt[k] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign m0_valid = r_valid[0];
  assign m0_data  = r_data[0];
  assign m0_last  = r_last[0];
  assign m1_valid = r_valid[1];
  assign m1_data  = r_data[1];
  assign m1_last  = r_last[1];
  assign pkt_cnt0 = r_cnt[0];
  assign pkt_cnt1 = r_cnt[1];

endmodule

// File: tb/tb_stream_demux2.sv
// tb_stream_demux2: randomized and directed stimulus for stream_demux2,
// checked every cycle against a queue-based model of packet routing.
module tb_stream_demux2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_sel = 1'b0;
  logic       m0_valid, m1_valid;
  logic       m0_ready = 1'b0, m1_ready = 1'b0;
  logic [7:0] m0_data, m1_data;
  logic       m0_last, m1_last;
  logic [7:0] pkt_cnt0, pkt_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_demux2 #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_sel(s_sel),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data), .m0_last(m0_last),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data), .m1_last(m1_last),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready generation: per-output mode (0 low, 1 high, 2 random), with an
  // optional one-shot pattern queue that takes priority.
  int   rdy_mode0 = 1, rdy_mode1 = 1;
  bit   pat0 [$];
  always @(posedge clk) begin
    #2;
    if (pat0.size() != 0) m0_ready = pat0.pop_front();
    else if (rdy_mode0 == 2) m0_ready = 1'($urandom_range(0, 1));
    else m0_ready = (rdy_mode0 == 1);
    if (rdy_mode1 == 2) m1_ready = 1'($urandom_range(0, 1));
    else m1_ready = (rdy_mode1 == 1);
  end

  // Model: each output is an ordered list of beats still owed downstream,
  // plus the route of the packet in progress (-1 = between packets).
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  int         route = -1;
  int         cnt0 = 0, cnt1 = 0;

  always @(negedge clk) begin
    int  t;
    bit  exp_rdy;
    if (!rst_n) begin
      q0.delete(); q1.delete(); route = -1; cnt0 = 0; cnt1 = 0;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m0_valid", 32'(m0_valid), 32'd0);
      chk("rst_m1_valid", 32'(m1_valid), 32'd0);
      chk("rst_cnt0", 32'(pkt_cnt0), 32'd0);
      chk("rst_cnt1", 32'(pkt_cnt1), 32'd0);
    end else begin
      t = (route < 0) ? int'(s_sel) : route;
      exp_rdy = (t == 0) ? (q0.size() == 0 || m0_ready) : (q1.size() == 0 || m1_ready);
      chk("s_ready", 32'(s_ready), 32'(exp_rdy));
      chk("m0_valid", 32'(m0_valid), 32'(q0.size() != 0));
      chk("m1_valid", 32'(m1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) chk("m0_beat", {23'd0, m0_last, m0_data}, 32'(q0[0]));
      if (q1.size() != 0) chk("m1_beat", {23'd0, m1_last, m1_data}, 32'(q1[0]));
      chk("pkt_cnt0", 32'(pkt_cnt0), 32'(cnt0 % 256));
      chk("pkt_cnt1", 32'(pkt_cnt1), 32'(cnt1 % 256));
      // Advance to the state after the coming rising edge.
      if (q0.size() != 0 && m0_ready) begin
        if (q0[0][8]) cnt0++;
        void'(q0.pop_front());
      end
      if (q1.size() != 0 && m1_ready) begin
        if (q1[0][8]) cnt1++;
        void'(q1.pop_front());
      end
      if (s_valid && exp_rdy) begin
        if (t == 0) q0.push_back({s_last, s_data});
        else        q1.push_back({s_last, s_data});
        route = s_last ? -1 : t;
      end
    end
  end

  // Drive one beat starting at posedge+1; returns at posedge+1 after accept.
  task automatic send_beat(input logic [7:0] d, input bit l, input bit sel, output int waits);
    bit acc;
    waits = 0;
    s_valid = 1'b1; s_data = d; s_last = l; s_sel = sel;
    forever begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      if (acc) break;
      waits++;
      if (waits > 300) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    #1;
    s_valid = 1'b0;
    s_data = 8'($urandom); s_last = 1'($urandom); s_sel = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_data = 8'($urandom); s_last = 1'($urandom); s_sel = 1'($urandom);
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    forever begin
      @(negedge clk);
      if (!m0_valid && !m1_valid) break;
      c++;
      if (c > 300) begin
        chk("drain_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int w, wsum;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // 3-beat packet to output 0
    wsum = 0;
    send_beat(8'hA1, 0, 0, w); wsum += w;
    send_beat(8'hA2, 0, 1, w); wsum += w;
    send_beat(8'hA3, 1, 1, w); wsum += w;
    wait_drain();
    chk("t1_cnt0", 32'(pkt_cnt0), 32'd1);
    chk("t1_cnt1", 32'(pkt_cnt1), 32'd0);
    chk("t1_stalls", 32'(wsum), 32'd0);
    $display("t1 done: cnt0=%0d cnt1=%0d", pkt_cnt0, pkt_cnt1);

    // 4-beat packet locked to output 1 despite s_sel toggling
    send_beat(8'hB1, 0, 1, w);
    send_beat(8'hB2, 0, 0, w);
    send_beat(8'hB3, 0, 0, w);
    send_beat(8'hB4, 1, 0, w);
    send_beat(8'hB5, 1, 0, w);   // proves FSM back in IDLE: lands on output 0
    wait_drain();
    chk("t2_cnt1", 32'(pkt_cnt1), 32'd1);
    chk("t2_cnt0", 32'(pkt_cnt0), 32'd2);
    $display("t2 done: cnt0=%0d cnt1=%0d", pkt_cnt0, pkt_cnt1);

    // Stalled output 1 must not block output 0
    rdy_mode1 = 0;
    @(posedge clk); #1;
    send_beat(8'h55, 1, 1, w);
    wsum = 0;
    send_beat(8'hC1, 0, 0, w); wsum += w;
    send_beat(8'hC2, 1, 1, w); wsum += w;
    @(negedge clk);
    chk("t3_stalls", 32'(wsum), 32'd0);
    chk("t3_m1_held_valid", 32'(m1_valid), 32'd1);
    chk("t3_m1_held_data", 32'(m1_data), 32'h55);
    @(posedge clk); #1;
    rdy_mode1 = 1;
    wait_drain();
    chk("t3_cnt0", 32'(pkt_cnt0), 32'd3);
    chk("t3_cnt1", 32'(pkt_cnt1), 32'd2);
    $display("t3 done: cnt0=%0d cnt1=%0d", pkt_cnt0, pkt_cnt1);

    // Back-pressure 1,0,0,1 on output 0 during a 5-beat packet
    pat0.push_back(1'b1); pat0.push_back(1'b0); pat0.push_back(1'b0); pat0.push_back(1'b1);
    wsum = 0;
    for (int i = 0; i < 5; i++) begin
      send_beat(8'hD0 + 8'(i), i == 4, 0, w);
      wsum += w;
    end
    wait_drain();
    chk("t4_stalls", 32'(wsum), 32'd2);
    chk("t4_cnt0", 32'(pkt_cnt0), 32'd4);
    $display("t4 done: stalls=%0d cnt0=%0d", wsum, pkt_cnt0);

    // Back-to-back single-beat packets, alternating outputs
    wsum = 0;
    for (int i = 0; i < 4; i++) begin
      send_beat(8'hE0 + 8'(i), 1, i[0], w);
      wsum += w;
    end
    wait_drain();
    chk("t5_stalls", 32'(wsum), 32'd0);
    chk("t5_cnt0", 32'(pkt_cnt0), 32'd6);
    chk("t5_cnt1", 32'(pkt_cnt1), 32'd4);
    $display("t5 done: cnt0=%0d cnt1=%0d", pkt_cnt0, pkt_cnt1);

    // Reset in the middle of a packet to output 1
    send_beat(8'hF1, 0, 1, w);
    send_beat(8'hF2, 0, 0, w);
    @(negedge clk);
    chk("t6_pre_m1_valid", 32'(m1_valid), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_m1_valid", 32'(m1_valid), 32'd0);
    chk("t6_cnt0", 32'(pkt_cnt0), 32'd0);
    chk("t6_cnt1", 32'(pkt_cnt1), 32'd0);
    chk("t6_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(8'h77, 1, 0, w);
    @(negedge clk);
    chk("t6_new_on_m0", {31'd0, m0_valid}, 32'd1);
    chk("t6_new_data", 32'(m0_data), 32'h77);
    @(posedge clk); #1;
    wait_drain();
    $display("t6 done: cnt0=%0d cnt1=%0d", pkt_cnt0, pkt_cnt1);

    // Counter wrap: 255 more single-beat packets to output 0
    for (int i = 0; i < 254; i++) send_beat(8'(i), 1, 0, w);
    wait_drain();
    chk("t7_cnt0_255", 32'(pkt_cnt0), 32'd255);
    send_beat(8'h99, 1, 0, w);
    wait_drain();
    chk("t7_cnt0_wrap", 32'(pkt_cnt0), 32'd0);
    $display("t7 done: cnt0=%0d", pkt_cnt0);

    // Randomized traffic with random back-pressure on both outputs
    rdy_mode0 = 2; rdy_mode1 = 2;
    for (int p = 0; p < 200; p++) begin
      int  len;
      bit  sel;
      len = $urandom_range(1, 4);
      sel = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) begin
        send_beat(8'($urandom), b == len - 1, (b == 0) ? sel : 1'($urandom), w);
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      end
      $display("rand pkt %0d: len=%0d sel=%0d", p, len, sel);
    end
    rdy_mode0 = 1; rdy_mode1 = 1;
    wait_drain();
    chk("rand_q0_empty", 32'(q0.size()), 32'd0);
    chk("rand_q1_empty", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_demux2.md
Name: stream_demux2

Overview:
- Registered 1-to-2 stream demultiplexer; it is the distribution-side counterpart of the team's 2:1 select mux.
- Accepts a single valid/ready packet stream and steers each whole packet to output 0 or output 1.
- The route is chosen by a select input sampled on a packet's first beat and locked until that packet's last beat.
- Each output has a one-entry pipeline register, giving full throughput and independent back-pressure per output.

Parameters:
- DATA_W, 8, width of the data bus on the input and both outputs.
- CNT_W, 8, width of each per-output completed-packet counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat can be accepted this cycle.
- s_data  input  DATA_W  input beat data.
- s_last  input  1  marks the final beat of a packet.
- s_sel  input  1  route for a new packet (0 → output 0, 1 → output 1); sampled only in IDLE.
- m0_valid, m1_valid  output  1  output k holds a beat.
- m0_ready, m1_ready  input  1  downstream k accepts the beat.
- m0_data, m1_data  output  DATA_W  output k data.
- m0_last, m1_last  output  1  output k end-of-packet.
- pkt_cnt0, pkt_cnt1  output  CNT_W  completed packets delivered on output k.

Behaviour:
- Reset:
  - Asynchronous on rst_n low. State goes to IDLE.
  - m0_valid = m1_valid = 0; m*_data = 0; m*_last = 0; pkt_cnt0 = pkt_cnt1 = 0.
  - s_ready is forced 0 while rst_n is low.
- FSM states:
  - IDLE: no packet in progress.
  - ROUTE0: packet locked to output 0.
  - ROUTE1: packet locked to output 1.
- Target t:
  - In IDLE, t = s_sel.
  - In ROUTE0, t = 0; in ROUTE1, t = 1. s_sel is ignored outside IDLE.
- s_ready = rst_n & (!m_valid_t | m_ready_t). This is combinational from the target output register; there is no combinational path from s_valid.
- Accept = s_valid & s_ready. Only handshaken beats change state.
- On accept:
  - Register t loads s_data and s_last, and m_valid_t = 1 on the next cycle. Input-to-output latency is 1 cycle.
  - If s_last = 1, next state is IDLE.
  - Otherwise, in IDLE the next state is ROUTE_t; in ROUTEk the state is held.
- Single-beat packet (first beat has s_last = 1): the beat is routed by s_sel and the FSM stays in IDLE.
- Output register k:
  - Cleared (m_valid_k = 0) when m_valid_k & m_ready_k and no new load this cycle.
  - Simultaneous drain and load keeps m_valid_k = 1 with the new beat, giving one beat per cycle sustained.
  - m_data_k and m_last_k hold stable while m_valid_k & !m_ready_k.
- Non-target output: unaffected by input traffic and drains independently. A stalled output 1 never blocks a packet routed to output 0.
- s_valid = 1 with no accept: nothing changes, and s_sel is re-sampled the next cycle if still in IDLE.
- Counters:
  - pkt_cntk increments by 1 on each output-k handshake where m_last_k = 1.
  - Wraps modulo 2^CNT_W (255 → 0 for the default).
- Reset mid-packet: all registered beats are discarded, the FSM returns to IDLE, and the next accepted beat is treated as a new packet using s_sel.
- X on s_sel, s_data, or s_last while s_valid = 0 must not affect state.

Test Plan:
- Reset, then 3-beat packet A1,A2,A3 with s_sel=0, m0_ready=1 → beats appear on m0 one cycle after each accept; m0_last only with A3; pkt_cnt0=1; m1_valid stays 0.
- 4-beat packet with s_sel=1 on beat 1, s_sel toggled to 0 on beats 2–4 → all 4 beats appear on m1; pkt_cnt1=1; FSM in IDLE after beat 4.
- Hold m1_ready=0 with a 1-beat packet sitting in output 1, then send a 2-beat packet to output 0 → output-0 packet completes with s_ready=1 throughout; output 1 keeps its beat until m1_ready=1.
- Back-pressure: m0_ready pattern 1,0,0,1 during a 5-beat packet to output 0 → s_ready low exactly while m0 is full and not ready; no beat lost or duplicated; order preserved.
- Back-to-back single-beat packets with s_sel = 0,1,0,1 at full rate → each output receives 2 beats; pkt_cnt0 = pkt_cnt1 = 2; no bubble cycles.
- Assert rst_n low after beat 2 of a 4-beat packet to output 1 → m1_valid = 0 and counters = 0 immediately; a subsequent packet with s_sel=0 lands on output 0. Separately, send 256 single-beat packets to output 0 → pkt_cnt0 wraps to 0.
